receiver_uart: RTL and testbench
================================

RECEIVER_UART -- requirements
Module: receiver_uart

Interface
REQ-001 SHALL have parameter clk_freq_hz, default 100000000, meaning the frequency of i_clk in Hz.
REQ-002 SHALL have parameter baud_rate, default 1000000, meaning the serial bit rate in bits/s.
REQ-003 SHALL have parameter fifo_depth, default 4, meaning the number of received bytes buffered (power of two, >= 2).
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_uart_rx  input  1  asynchronous serial line, 8N1, LSB first, idles high.
REQ-007 o_data  output  8  oldest buffered byte; 8'h00 whenever o_valid = 0.
REQ-008 o_valid  output  1  FIFO non-empty; o_data is valid.
REQ-009 i_ready  input  1  consumer accepts o_data; pop occurs on a cycle where o_valid & i_ready.
REQ-010 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 o_overrun  output  1  one-cycle pulse: received byte dropped because the FIFO was full.

Function
REQ-012 CPB = clk_freq_hz/baud_rate (integer division); SHALL require CPB >= 4 (elaboration-time check).
REQ-013 i_uart_rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); the FSM SHALL use only the synchronized value rx_s.
REQ-014 FSM states: IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: on rx_s = 0 -> START, bit-timer loaded with CPB/2 - 1.
REQ-016 Bit-timer SHALL count down once per cycle; a "sample tick" is the cycle on which it equals 0.
REQ-017 START at sample tick: rx_s = 0 -> DATA, timer = CPB-1, bit index = 0; rx_s = 1 -> IDLE (glitch rejected, no output event).
REQ-018 DATA at each sample tick: shift rx_s into the shift register LSB-first, timer = CPB-1; after bit index 7 -> STOP.
REQ-019 STOP at sample tick, rx_s = 1: push byte into the FIFO, -> IDLE on the next cycle (a new start edge detected from that cycle on).
REQ-020 STOP at sample tick, rx_s = 0: discard byte, pulse o_frame_err for exactly 1 cycle, -> BREAK.
REQ-021 BREAK: stay until rx_s = 1, then -> IDLE; no start detection while in BREAK.
REQ-022 Push latency: o_valid SHALL be high on the cycle after the stop-bit sample tick when the FIFO was empty.
REQ-023 FIFO full at push with no simultaneous pop: byte dropped, FIFO contents unchanged, o_overrun pulses 1 cycle.
REQ-024 FIFO full at push with simultaneous pop: both pop and push occur, no overrun.
REQ-025 Pop when o_valid = 0 SHALL be ignored; read/write pointers wrap modulo fifo_depth; a full/empty distinction SHALL use an extra pointer bit or a count.
REQ-026 Output order SHALL equal reception order.
REQ-027 o_frame_err and o_overrun SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-028 On i_reset = 1 at a clock edge: FSM -> IDLE, FIFO emptied, synchronizer = 1, timer/bit index/shift register = 0.
REQ-029 After reset: o_valid = 0, o_data = 8'h00, o_frame_err = 0, o_overrun = 0.
REQ-030 Reset during an in-flight frame SHALL abort it with no push and no error pulse; the remainder of that frame's bits SHALL be treated as fresh line activity from IDLE.

Verification (clk_freq_hz = 1600000, baud_rate = 100000 -> CPB = 16, fifo_depth = 4)
REQ-031 Send 8'hA5 with i_ready = 1 -> o_valid high exactly 1 cycle, o_data = 8'hA5, no error pulses.
REQ-032 Send 8'h01, 8'h80, 8'hFF, 8'h00 back-to-back with i_ready = 0 -> FIFO full; then i_ready = 1 -> bytes popped in that order.
REQ-033 FIFO holding 4 bytes, send 8'h3C with i_ready = 0 -> o_overrun pulses 1 cycle, FIFO contents unchanged; repeat with a pop on the push cycle -> no overrun, 8'h3C appears last.
REQ-034 Frame 8'h55 with stop bit held low for 40 bit times -> o_frame_err pulses once, no push; after the line returns high, 8'h12 -> received correctly.
REQ-035 Low glitch on i_uart_rx of 5 cycles (< CPB/2) -> no state change beyond START, no output event.
REQ-036 Assert i_reset for 1 cycle during bit 3 of 8'hC3 -> all outputs 0 the next cycle; a following clean 8'h7E -> received correctly.

Source files
------------

// File: rtl/receiver_uart.sv
// receiver_uart -- 8N1 serial receiver with a small output FIFO.
//
// The asynchronous line is double-flopped. Every start edge is confirmed at
// mid-bit, and each data bit is sampled at the centre of its bit cell.
// Received bytes are pushed into a FIFO. A byte is popped on any cycle where
// o_valid and i_ready are both high.
//
// Ports
//   i_clk        system clock; all state changes on its rising edge
//   i_reset      synchronous, active-high reset
//   i_uart_rx    asynchronous serial input (idles high, LSB first)
//   o_data       oldest buffered byte; forced to 8'h00 while o_valid = 0
//   o_valid      FIFO holds at least one byte
//   i_ready      consumer accepts o_data this cycle
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_overrun    one-cycle pulse when a received byte is dropped (FIFO full)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// st_idle  | line idle, waiting for rx_s = 0
// st_start | timing half a bit to confirm the start bit
// st_data  | sampling the 8 data bits at mid-bit
// st_stop  | sampling the stop bit; push on high, frame error on low
// st_break | line held low after a framing error; wait for it to go high

module receiver_uart #(
    parameter int clk_freq_hz = 100000000,
    parameter int baud_rate   = 1000000,
    parameter int fifo_depth  = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int cpb   = clk_freq_hz / baud_rate;
    localparam int tmr_w = $clog2(cpb);
    localparam int ptr_w = $clog2(fifo_depth);

    localparam logic [tmr_w-1:0] tmr_half = tmr_w'(cpb / 2 - 1);
    localparam logic [tmr_w-1:0] tmr_full = tmr_w'(cpb - 1);
    localparam logic [tmr_w-1:0] tmr_one  = tmr_w'(1);
    localparam logic [ptr_w:0]   ptr_one  = (ptr_w + 1)'(1);

    localparam logic [2:0] st_idle  = 3'd0;
    localparam logic [2:0] st_start = 3'd1;
    localparam logic [2:0] st_data  = 3'd2;
    localparam logic [2:0] st_stop  = 3'd3;
    localparam logic [2:0] st_break = 3'd4;

    if (cpb < 4) begin : g_bad_cpb
        $error("receiver_uart: clk_freq_hz / baud_rate must be at least 4");
    end

    if ((fifo_depth < 2) || ((fifo_depth & (fifo_depth - 1)) != 0)) begin : g_bad_depth
        $error("receiver_uart: fifo_depth must be a power of two, at least 2");
    end

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [tmr_w-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             frame_err_q;
    logic             overrun_q;

    logic [7:0]       mem [fifo_depth];
    logic [ptr_w:0]   wr_ptr;
    logic [ptr_w:0]   rd_ptr;

    logic tick;
    logic push;
    logic pop;
    logic wr_en;
    logic fifo_empty;
    logic fifo_full;

    assign tick       = (timer == '0);
    assign push       = (state == st_stop) && tick && rx_s;
    // The extra pointer MSB tells full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ptr_w] != rd_ptr[ptr_w]) &&
                        (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]);
    assign pop        = o_valid && i_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot being written.
    assign wr_en      = push && (!fifo_full || pop);

    // Both flops reset high, so a reset never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= st_idle;
            timer       <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state)
                st_idle: begin
                    if (!rx_s) begin
                        state <= st_start;
                        timer <= tmr_half;
                    end
                end
                st_start: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state   <= st_data;
                            timer   <= tmr_full;
                            bit_idx <= '0;
                        end else begin
                            state <= st_idle;
                        end
                    end else begin
                        timer <= timer - tmr_one;
                    end
                end
                st_data: begin
                    if (tick) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        timer     <= tmr_full;
                        if (bit_idx == 3'd7) begin
                            state <= st_stop;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - tmr_one;
                    end
                end
                st_stop: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= st_idle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= st_break;
                        end
                    end else begin
                        timer <= timer - tmr_one;
                    end
                end
                st_break: begin
                    if (rx_s) begin
                        state <= st_idle;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    // Storage has no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr[ptr_w-1:0]] <= shift_reg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && fifo_full && !pop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ptr_one;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_one;
            end
        end
    end

    assign o_valid     = !fifo_empty;
    assign o_data      = o_valid ? mem[rd_ptr[ptr_w-1:0]] : 8'h00;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_receiver_uart.sv
// Directed bench for receiver_uart at 16 clocks per bit with a 4-entry FIFO.
// Inputs are driven 1 time unit after a rising edge. Outputs are observed on
// the falling edge by a monitor that logs every popped byte and counts pulses.

module tb_receiver_uart;

    localparam int bt = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    receiver_uart #(
        .clk_freq_hz(1600000),
        .baud_rate  (100000),
        .fifo_depth (4)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_uart_rx  (uart_rx),
        .o_data     (data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_frame_err(frame_err),
        .o_overrun  (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] pop_q[$];
    int   valid_cycles = 0;
    int   fe_pulses    = 0;
    int   fe_long      = 0;
    int   ov_pulses    = 0;
    int   ov_long      = 0;
    int   bad_data     = 0;
    logic fe_prev      = 1'b0;
    logic ov_prev      = 1'b0;

    always @(negedge clk) begin
        if (valid && ready) pop_q.push_back(data);
        if (valid) valid_cycles++;
        if (!valid && data !== 8'h00) bad_data++;
        if (frame_err && !fe_prev) fe_pulses++;
        if (frame_err && fe_prev) fe_long++;
        if (overrun && !ov_prev) ov_pulses++;
        if (overrun && ov_prev) ov_long++;
        fe_prev = frame_err;
        ov_prev = overrun;
    end

    function automatic logic [31:0] pop_at(input int i);
        if (i < pop_q.size()) return {24'h0, pop_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        uart_rx = v;
        wait_cycles(n);
    endtask

    task automatic send_head(input logic [7:0] b);
        drive_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) drive_bit(b[i], bt);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b);
        drive_bit(1'b1, bt);
    endtask

    // The stop bit is sampled 11 cycles into the stop cell: 2 synchroniser
    // cycles, 1 for the idle->start step, then 8 + 16*9 timer cycles from the
    // start edge. Ready is raised for exactly that cycle.
    task automatic send_byte_pop_on_push(input logic [7:0] b);
        send_head(b);
        drive_bit(1'b1, 10);
        ready = 1'b1;
        drive_bit(1'b1, 1);
        ready = 1'b0;
        drive_bit(1'b1, 5);
    endtask

    task automatic drain();
        ready = 1'b1;
        wait_cycles(10);
        ready = 1'b0;
    endtask

    int s_q, s_v, s_fe, s_ov, s_fel, s_ovl;

    task automatic snap();
        s_q   = pop_q.size();
        s_v   = valid_cycles;
        s_fe  = fe_pulses;
        s_ov  = ov_pulses;
        s_fel = fe_long;
        s_ovl = ov_long;
    endtask

    logic [7:0] exp4 [4];
    logic [7:0] c3;

    initial begin
        reset   = 1'b1;
        ready   = 1'b0;
        uart_rx = 1'b1;
        wait_cycles(3);
        check("rst_valid", valid, 0);
        check("rst_data", data, 8'h00);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        wait_cycles(20);

        // One byte with the consumer always ready.
        snap();
        ready = 1'b1;
        send_byte(8'hA5);
        wait_cycles(20);
        check("a5_pop_count", pop_q.size() - s_q, 1);
        check("a5_data", pop_at(s_q), 8'hA5);
        check("a5_valid_cycles", valid_cycles - s_v, 1);
        check("a5_frame_err", fe_pulses - s_fe, 0);
        check("a5_overrun", ov_pulses - s_ov, 0);
        ready = 1'b0;

        // Fill the FIFO back-to-back, then drain it.
        snap();
        exp4[0] = 8'h01; exp4[1] = 8'h80; exp4[2] = 8'hFF; exp4[3] = 8'h00;
        for (int i = 0; i < 4; i++) send_byte(exp4[i]);
        wait_cycles(20);
        check("fill_valid", valid, 1);
        check("fill_head", data, 8'h01);
        check("fill_no_pop", pop_q.size() - s_q, 0);
        drain();
        check("fill_pop_count", pop_q.size() - s_q, 4);
        for (int i = 0; i < 4; i++) check($sformatf("fill_order_%0d", i), pop_at(s_q + i), exp4[i]);
        check("fill_empty", valid, 0);

        // Overrun: a fifth byte while full is dropped.
        snap();
        exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
        for (int i = 0; i < 4; i++) send_byte(exp4[i]);
        send_byte(8'h3C);
        wait_cycles(20);
        check("ovr_pulse", ov_pulses - s_ov, 1);
        check("ovr_pulse_width", ov_long - s_ovl, 0);
        check("ovr_head", data, 8'h11);
        drain();
        check("ovr_pop_count", pop_q.size() - s_q, 4);
        for (int i = 0; i < 4; i++) check($sformatf("ovr_order_%0d", i), pop_at(s_q + i), exp4[i]);

        // Full FIFO with a pop on the push cycle: no overrun, 3C goes last.
        snap();
        for (int i = 0; i < 4; i++) send_byte(exp4[i]);
        send_byte_pop_on_push(8'h3C);
        wait_cycles(20);
        check("popush_overrun", ov_pulses - s_ov, 0);
        check("popush_head", data, 8'h22);
        drain();
        check("popush_pop_count", pop_q.size() - s_q, 5);
        for (int i = 0; i < 4; i++) check($sformatf("popush_order_%0d", i), pop_at(s_q + i), exp4[i]);
        check("popush_last", pop_at(s_q + 4), 8'h3C);

        // Framing error: stop bit held low for 40 bit times.
        ready = 1'b1;
        snap();
        send_head(8'h55);
        drive_bit(1'b0, 40 * bt);
        drive_bit(1'b1, 2 * bt);
        check("ferr_pulse", fe_pulses - s_fe, 1);
        check("ferr_pulse_width", fe_long - s_fel, 0);
        check("ferr_no_push", valid_cycles - s_v, 0);
        send_byte(8'h12);
        wait_cycles(20);
        check("ferr_recover_count", pop_q.size() - s_q, 1);
        check("ferr_recover_data", pop_at(s_q), 8'h12);

        // A 5-cycle low glitch is rejected at the mid-start check.
        snap();
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 40);
        check("glitch_no_valid", valid_cycles - s_v, 0);
        check("glitch_no_ferr", fe_pulses - s_fe, 0);
        check("glitch_no_ovr", ov_pulses - s_ov, 0);
        send_byte(8'h5A);
        wait_cycles(20);
        check("glitch_after_data", pop_at(s_q), 8'h5A);

        // Reset during bit 3 of C3. The reset lands on the first edge of bit 3.
        // The still-low line then reads as a new start. Its samples fall in
        // bit 3 (start), then bits 4..7 = 0,0,1,1, then the stop bit and idle
        // as 1,1,1,1. The result is 8'hFC, followed by a high stop.
        snap();
        c3 = 8'hC3;
        drive_bit(1'b0, bt);
        for (int i = 0; i < 3; i++) drive_bit(c3[i], bt);
        uart_rx = c3[3];
        reset   = 1'b1;
        wait_cycles(1);
        reset   = 1'b0;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_overrun", overrun, 0);
        drive_bit(c3[3], bt - 1);
        for (int i = 4; i < 8; i++) drive_bit(c3[i], bt);
        drive_bit(1'b1, bt);
        drive_bit(1'b1, 100);
        check("mid_rst_no_ferr", fe_pulses - s_fe, 0);
        check("mid_rst_residue", pop_at(s_q), 8'hFC);
        send_byte(8'h7E);
        wait_cycles(20);
        check("mid_rst_pop_count", pop_q.size() - s_q, 2);
        check("mid_rst_7e", pop_at(s_q + 1), 8'h7E);

        check("data_zero_when_invalid", bad_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
